// File: rtl/cordic_vec_pkg.sv
// Shared types and constants for the vectoring-mode CORDIC (magnitude / atan2).
// Arctangent table is in binary-angle units: 0x8000 = pi, LSB = pi/32768.
package cordic_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          ATAN_N   = 14;
    localparam int          INV_K    = 19898;
    localparam logic [15:0] ANGLE_PI = 16'h8000;

    function automatic logic [15:0] atan_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lookup = 16'd8192;
            4'd1:    atan_lookup = 16'd4836;
            4'd2:    atan_lookup = 16'd2555;
            4'd3:    atan_lookup = 16'd1297;
            4'd4:    atan_lookup = 16'd651;
            4'd5:    atan_lookup = 16'd326;
            4'd6:    atan_lookup = 16'd163;
            4'd7:    atan_lookup = 16'd81;
            4'd8:    atan_lookup = 16'd41;
            4'd9:    atan_lookup = 16'd20;
            4'd10:   atan_lookup = 16'd10;
            4'd11:   atan_lookup = 16'd5;
            4'd12:   atan_lookup = 16'd3;
            4'd13:   atan_lookup = 16'd1;
            default: atan_lookup = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_iter.sv
// One combinational vectoring micro-rotation: drives y toward zero,
// accumulating the rotated angle in z (z wraps modulo 2^16 by design).
module cordic_vec_iter
    import cordic_vec_pkg::*;
#(
    parameter int INT_W = 19
) (
    input  logic signed [INT_W-1:0] i_x,
    input  logic signed [INT_W-1:0] i_y,
    input  logic        [15:0]      i_z,
    input  logic        [3:0]       i_iter,
    input  logic        [15:0]      i_atan,
    output logic signed [INT_W-1:0] o_x,
    output logic signed [INT_W-1:0] o_y,
    output logic        [15:0]      o_z
);

    logic                    w_d_pos;
    logic signed [INT_W-1:0] w_x_sh;
    logic signed [INT_W-1:0] w_y_sh;

    assign w_d_pos = ~i_y[INT_W-1];
    assign w_x_sh  = i_x >>> i_iter;
    assign w_y_sh  = i_y >>> i_iter;

    assign o_x = w_d_pos ? (i_x + w_y_sh) : (i_x - w_y_sh);
    assign o_y = w_d_pos ? (i_y - w_x_sh) : (i_y + w_x_sh);
    assign o_z = w_d_pos ? (i_z + i_atan) : (i_z - i_atan);

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (x, y) -> (magnitude, atan2) with valid/ready on both sides.
// Optional macro CORDIC_VEC_GAIN_COMP_EN adds a COMP state that removes the CORDIC gain.
//
// state | meaning
// IDLE  | in_ready high, waiting for a vector
// RUN   | one micro-rotation per cycle, iter 0..ITER-1
// COMP  | gain compensation multiply (macro builds only)
// DONE  | out_valid high, result held until out_ready
module cordic_vectoring
    import cordic_vec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ITER   = 14,
    parameter int INT_W  = DATA_W + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W+1:0] mag_out,
    output logic [15:0]       angle_out
);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [INT_W-1:0] r_x;
    logic signed [INT_W-1:0] r_y;
    logic        [15:0]      r_z;
    logic        [3:0]       r_iter;
    logic                    r_zero;
    logic        [DATA_W+1:0] r_mag;
    logic        [15:0]      r_angle;

    logic signed [INT_W-1:0] w_x_ext;
    logic signed [INT_W-1:0] w_y_ext;
    logic signed [INT_W-1:0] w_x_nxt;
    logic signed [INT_W-1:0] w_y_nxt;
    logic        [15:0]      w_z_nxt;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_out_load;
    logic        [DATA_W+1:0] w_mag_res;
    logic        [15:0]      w_angle_res;

    // Sign-extend first so that negating -2^(DATA_W-1) does not overflow.
    assign w_x_ext  = {{(INT_W-DATA_W){x_in[DATA_W-1]}}, x_in};
    assign w_y_ext  = {{(INT_W-DATA_W){y_in[DATA_W-1]}}, y_in};
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_iter == 4'(ITER-1));

    cordic_vec_iter #(
        .INT_W (INT_W)
    ) u_iter (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_iter (r_iter),
        .i_atan (atan_lookup(r_iter)),
        .o_x    (w_x_nxt),
        .o_y    (w_y_nxt),
        .o_z    (w_z_nxt)
    );

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int PROD_W = INT_W + 16;
    logic [PROD_W-1:0] w_prod;

    // x is non-negative after pre-rotation, so an unsigned multiply is exact.
    assign w_prod      = PROD_W'($unsigned(r_x)) * PROD_W'(INV_K);
    assign w_out_load  = (r_state == COMP);
    assign w_mag_res   = (DATA_W+2)'((w_prod + PROD_W'(1 << 14)) >> 15);
    assign w_angle_res = r_z;
`else
    assign w_out_load  = w_last;
    assign w_mag_res   = w_x_nxt[DATA_W+1:0];
    assign w_angle_res = w_z_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (r_iter == 4'(ITER-1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    w_state_nxt = COMP;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
            COMP: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        mag_out   = r_mag;
        angle_out = r_angle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_zero  <= 1'b0;
            r_mag   <= '0;
            r_angle <= '0;
        end else begin
            if (w_accept) begin
                r_iter <= '0;
                r_zero <= (x_in == '0) && (y_in == '0);
                if (x_in[DATA_W-1]) begin
                    r_x <= -w_x_ext;
                    r_y <= -w_y_ext;
                    r_z <= ANGLE_PI;
                end else begin
                    r_x <= w_x_ext;
                    r_y <= w_y_ext;
                    r_z <= '0;
                end
            end else if (r_state == RUN) begin
                r_x    <= w_x_nxt;
                r_y    <= w_y_nxt;
                r_z    <= w_z_nxt;
                r_iter <= r_iter + 4'd1;
            end

            // Zero vectors still take full latency; the result is simply forced.
            if (w_out_load) begin
                r_mag   <= r_zero ? '0 : w_mag_res;
                r_angle <= r_zero ? '0 : w_angle_res;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: directed and random vectors against
// an ideal atan2/hypot model, plus handshake, backpressure and reset scenarios.
module tb_cordic_vectoring;

    localparam int  DATA_W = 16;
    localparam int  ITER   = 14;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT     = ITER + 1;
    localparam bit  COMP_EN = 1'b1;
`else
    localparam int  LAT     = ITER;
    localparam bit  COMP_EN = 1'b0;
`endif
    localparam real PI_R = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] x_in = '0;
    logic [DATA_W-1:0] y_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W+1:0] mag_out;
    logic [15:0]       angle_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_vectoring dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic real gain_k();
        real k = 1.0;
        for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        return k;
    endfunction

    function automatic real model_mag(input int x, input int y);
        real m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        return COMP_EN ? m : m * gain_k();
    endfunction

    function automatic int model_angle(input int x, input int y);
        if (x == 0 && y == 0) return 0;
        return int'($floor($atan2(real'(y), real'(x)) * 32768.0 / PI_R + 0.5));
    endfunction

    function automatic real mag_tol(input real em);
        return em * 0.001 + (COMP_EN ? 3.0 : 2.0);
    endfunction

    function automatic int ang_err(input logic [15:0] got, input int expv);
        logic [15:0] d;
        int di;
        d  = got - 16'(expv);
        di = int'($signed(d));
        return (di < 0) ? -di : di;
    endfunction

    function automatic real abs_r(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_vec(input int x, input int y, output bit ok);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        x_in = 16'(x);
        y_in = 16'(y);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic get_result(output int lat, output logic [DATA_W+1:0] m, output logic [15:0] a);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        m = mag_out;
        a = angle_out;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || mag_out !== '0 || angle_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b mag=%0d ang=%0d, expected 0/0/0",
                     out_valid, mag_out, angle_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        int cx [5] = '{16384, 0, -16384, -32768, 0};
        int cy [5] = '{0, 16384, 0, -32768, 0};
        bit ok;
        int lat;
        logic [DATA_W+1:0] m;
        logic [15:0] a;
        real em;
        for (int i = 0; i < 5; i++) begin
            send_vec(cx[i], cy[i], ok);
            get_result(lat, m, a);
            total++;
            if (!ok || lat != LAT) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d (accepted=%0b), expected %0d", i, lat, ok, LAT);
            end
            em = model_mag(cx[i], cy[i]);
            if (cx[i] == 0 && cy[i] == 0) begin
                total++;
                if (m !== '0 || a !== '0) begin
                    bad++;
                    $display("FAIL dir%0d_zero: got mag=%0d ang=%0d, expected 0/0", i, m, a);
                end
            end else begin
                total++;
                if (ang_err(a, model_angle(cx[i], cy[i])) > 3) begin
                    bad++;
                    $display("FAIL dir%0d_angle: got %0d, expected %0d +-3", i, a, 16'(model_angle(cx[i], cy[i])));
                end
                total++;
                if (abs_r(real'(m) - em) > mag_tol(em)) begin
                    bad++;
                    $display("FAIL dir%0d_mag: got %0d, expected %0.1f +-%0.1f", i, m, em, mag_tol(em));
                end
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [DATA_W+1:0] m;
        logic [15:0] a;
        send_vec(12000, -5000, ok);
        get_result(lat, m, a);
        total++;
        if (!ok || lat != LAT) begin
            bad++;
            $display("FAIL bp_latency: got %0d, expected %0d", lat, LAT);
        end
        // Offer a competing vector while DONE; it must be ignored.
        in_valid = 1'b1;
        x_in = 16'(-3000);
        y_in = 16'(9000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || mag_out !== m || angle_out !== a || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%b mag=%0d ang=%0d rdy=%b, expected 1/%0d/%0d/0",
                         c, out_valid, mag_out, angle_out, in_ready, m, a);
            end
        end
        in_valid = 1'b0;
        total++;
        if (ang_err(a, model_angle(12000, -5000)) > 3) begin
            bad++;
            $display("FAIL bp_angle: got %0d, expected %0d +-3", a, 16'(model_angle(12000, -5000)));
        end
        release_out();
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cnt = 0;
        int lat;
        logic [DATA_W+1:0] m;
        logic [15:0] a;
        real em;
        send_vec(-20000, 15000, ok);
        @(negedge clk);
        while (!out_valid && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_in = 16'(7000);
        y_in = 16'(-21000);
        @(posedge clk);
        cnt++;
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_bubble: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        cnt++;
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || cnt != LAT + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got in_ready=%b spacing=%0d, expected 0/%0d", in_ready, cnt, LAT + 2);
        end
        get_result(lat, m, a);
        em = model_mag(7000, -21000);
        total++;
        if (lat != LAT - 1 || ang_err(a, model_angle(7000, -21000)) > 3 || abs_r(real'(m) - em) > mag_tol(em)) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d mag=%0d ang=%0d, expected lat=%0d mag=%0.1f ang=%0d",
                     lat + 1, m, a, LAT, em, 16'(model_angle(7000, -21000)));
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit seen = 1'b0;
        int lat;
        logic [DATA_W+1:0] m;
        logic [15:0] a;
        real em;
        send_vec(20000, 7000, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || mag_out !== '0 || angle_out !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got valid=%b mag=%0d ang=%0d, expected 0/0/0",
                     out_valid, mag_out, angle_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready: got in_ready=%b, expected 1", in_ready);
        end
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL midrst_stale: got out_valid=1 after abort, expected 0");
        end
        send_vec(-9000, -25000, ok);
        get_result(lat, m, a);
        em = model_mag(-9000, -25000);
        total++;
        if (lat != LAT || ang_err(a, model_angle(-9000, -25000)) > 3 || abs_r(real'(m) - em) > mag_tol(em)) begin
            bad++;
            $display("FAIL midrst_recover: got lat=%0d mag=%0d ang=%0d, expected lat=%0d mag=%0.1f ang=%0d",
                     lat, m, a, LAT, em, 16'(model_angle(-9000, -25000)));
        end
        release_out();
    endtask

    task automatic test_random();
        bit ok;
        int lat, x, y;
        logic [15:0] rv;
        logic [DATA_W+1:0] m;
        logic [15:0] a;
        real em;
        for (int n = 0; n < 12; n++) begin
            // Large vectors keep datapath truncation well inside the accuracy budget.
            do begin
                rv = 16'($urandom);
                x  = int'($signed(rv));
                rv = 16'($urandom);
                y  = int'($signed(rv));
            end while (longint'(x) * x + longint'(y) * y < 64'd268435456);
            send_vec(x, y, ok);
            get_result(lat, m, a);
            em = model_mag(x, y);
            total++;
            if (!ok || lat != LAT) begin
                bad++;
                $display("FAIL rnd%0d_latency: got %0d, expected %0d", n, lat, LAT);
            end
            total++;
            if (ang_err(a, model_angle(x, y)) > 4) begin
                bad++;
                $display("FAIL rnd%0d_angle: (%0d,%0d) got %0d, expected %0d +-4", n, x, y, a, 16'(model_angle(x, y)));
            end
            total++;
            if (abs_r(real'(m) - em) > mag_tol(em)) begin
                bad++;
                $display("FAIL rnd%0d_mag: (%0d,%0d) got %0d, expected %0.1f +-%0.1f", n, x, y, m, em, mag_tol(em));
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
